// File: rtl/bp_update_ctrl.sv
// Branch-predictor PHT update controller: sweeps the table to weakly-taken after reset,
// then drains resolved-branch updates from a small FIFO into the PHT write port.
module bp_update_ctrl #(
    parameter int L_IDX   = 4,
    parameter int Q_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_upd_valid,
    input  logic [31:0]      ex_upd_pc,
    input  logic             ex_upd_mispredict,
    output logic             ex_upd_ready,
    output logic             pht_wr_en,
    output logic [L_IDX-1:0] pht_wr_idx,
    output logic             pht_wr_init,
    output logic             pht_wr_mispredict,
    output logic             init_busy,
    output logic             flush_req,
    output logic [31:0]      br_count,
    output logic [31:0]      mp_count
);

    localparam int PW = $clog2(Q_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(Q_DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           r_state;
    logic [L_IDX-1:0] r_sweep;
    logic [L_IDX-1:0] r_q_idx [Q_DEPTH];
    logic             r_q_mp  [Q_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_flush;
    logic [31:0]      r_br_count;
    logic [31:0]      r_mp_count;

    logic w_full;
    logic w_enq;
    logic w_deq;

    // Full blocks enqueue even on a dequeue cycle, so ready never depends on the drain path.
    assign w_full       = (r_count == FULL_CNT);
    assign w_enq        = ex_upd_valid && !w_full;
    assign w_deq        = (r_state == S_RUN) && (r_count != '0);
    assign ex_upd_ready = !w_full;
    assign init_busy    = (r_state == S_INIT);
    assign flush_req    = r_flush;
    assign br_count     = r_br_count;
    assign mp_count     = r_mp_count;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        pht_wr_en         = 1'b0;
        pht_wr_idx        = '0;
        pht_wr_init       = 1'b0;
        pht_wr_mispredict = 1'b0;
        if (r_state == S_INIT) begin
            pht_wr_en   = 1'b1;
            pht_wr_idx  = r_sweep;
            pht_wr_init = 1'b1;
        end else if (w_deq) begin
            pht_wr_en         = 1'b1;
            pht_wr_idx        = r_q_idx[r_rd_ptr];
            pht_wr_mispredict = r_q_mp[r_rd_ptr];
        end
    end

    // NOTE: queue storage carries no reset; the occupancy counter alone defines validity.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_idx[r_wr_ptr] <= ex_upd_pc[L_IDX+1:2];
            r_q_mp[r_wr_ptr]  <= ex_upd_mispredict;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_sweep    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_flush    <= 1'b0;
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            if (r_state == S_INIT) begin
                r_sweep <= r_sweep + L_IDX'(1);
                if (r_sweep == '1) r_state <= S_RUN;
            end

            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase

            r_flush <= w_enq && ex_upd_mispredict;
            if (w_enq && r_br_count != '1) r_br_count <= r_br_count + 32'd1;
            if (w_enq && ex_upd_mispredict && r_mp_count != '1) r_mp_count <= r_mp_count + 32'd1;
        end
    end

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter L_IDX, default 4, meaning PHT index width (PHT has 2**L_IDX rows).
REQ-002 SHALL have parameter Q_DEPTH, default 4, meaning update-queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ex_upd_valid  input  1  EX stage presents a resolved conditional branch.
REQ-006 SHALL have port ex_upd_pc  input  32  PC of the resolved branch.
REQ-007 SHALL have port ex_upd_mispredict  input  1  prediction for that branch was wrong.
REQ-008 SHALL have port ex_upd_ready  output  1  controller accepts the update this cycle.
REQ-009 SHALL have port pht_wr_en  output  1  write strobe to the PHT.
REQ-010 SHALL have port pht_wr_idx  output  L_IDX  PHT row to write.
REQ-011 SHALL have port pht_wr_init  output  1  write forces the weakly-taken value 2'b01, not a counter step.
REQ-012 SHALL have port pht_wr_mispredict  output  1  counter-step direction for a non-init write.
REQ-013 SHALL have port init_busy  output  1  table initialisation sweep in progress.
REQ-014 SHALL have port flush_req  output  1  one-cycle front-end flush pulse after an accepted mispredict.
REQ-015 SHALL have port br_count  output  32  accepted branch updates since reset.
REQ-016 SHALL have port mp_count  output  32  accepted mispredicts since reset.

Function
REQ-017 SHALL implement FSM states INIT and RUN; INIT -> RUN on the cycle the sweep writes row 2**L_IDX-1; no other transitions except reset.
REQ-018 In INIT: SHALL assert pht_wr_en=1, pht_wr_init=1, init_busy=1, with pht_wr_idx taking the sweep counter 0,1,...,2**L_IDX-1, one row per cycle (sweep length exactly 2**L_IDX cycles).
REQ-019 Handshake: an update is accepted when ex_upd_valid && ex_upd_ready; ex_upd_ready = !queue_full, independent of FSM state (updates queue during INIT).
REQ-020 Queue entry SHALL hold {idx = ex_upd_pc[L_IDX+1:2], mispredict}; order strictly FIFO.
REQ-021 In RUN with queue non-empty: SHALL dequeue the head each cycle and drive pht_wr_en=1, pht_wr_init=0, pht_wr_idx/pht_wr_mispredict from the head entry; in RUN with queue empty, pht_wr_en=0.
REQ-022 Latency: an entry accepted in cycle N into an empty queue in RUN SHALL appear on the PHT write port in cycle N+1 (no same-cycle bypass).
REQ-023 Full: when occupancy = Q_DEPTH, ex_upd_ready=0 even if a dequeue occurs that cycle; simultaneous enqueue and dequeue at lower occupancy leaves occupancy unchanged.
REQ-024 Pointers SHALL wrap modulo Q_DEPTH; occupancy counter width log2(Q_DEPTH)+1.
REQ-025 flush_req SHALL be 1 in cycle N+1 exactly when an update with mispredict=1 is accepted in cycle N; otherwise 0; not suppressed in INIT.
REQ-026 br_count SHALL increment by 1 per accepted update; mp_count by 1 per accepted mispredict; both saturate at 32'hFFFF_FFFF.
REQ-027 pht_wr_mispredict SHALL be 0 whenever pht_wr_en=0 or pht_wr_init=1.

Reset
REQ-028 When rst=1 at a clock edge: state=INIT, sweep counter=0, queue empty, br_count=0, mp_count=0, flush_req=0; applies identically mid-sweep or mid-drain (pending entries discarded).
REQ-029 During the first cycle after rst deasserts: pht_wr_en=1, pht_wr_init=1, pht_wr_idx=0, init_busy=1, ex_upd_ready=1.

Verification
REQ-030 Reset then idle, L_IDX=4 -> 16 consecutive init writes idx 0..15, init_busy falls after idx 15, then pht_wr_en=0.
REQ-031 In RUN, accept pc=32'h0000_0024 mispredict=1 at cycle N -> cycle N+1: pht_wr_en=1, idx=9, pht_wr_mispredict=1, flush_req=1; br_count=1, mp_count=1.
REQ-032 During INIT push 5 updates back-to-back, Q_DEPTH=4 -> first 4 accepted, 5th sees ex_upd_ready=0 until the sweep ends; queued entries drain in order on consecutive cycles after INIT.
REQ-033 In RUN, continuous valid updates every cycle -> one write per cycle, occupancy stays <=1, ex_upd_ready never drops.
REQ-034 Assert rst with 3 entries queued and counters nonzero -> queue empty, counters 0, sweep restarts at idx 0, no stale entry ever written.
REQ-035 Preload br_count=32'hFFFF_FFFE via forced stimulus, accept 3 updates -> br_count holds 32'hFFFF_FFFF.
